// File: rtl/downscale_sequencer_if.sv
// downscale_sequencer_if: pixel-job handshake between the frame sequencer and the interpolation datapath
interface downscale_sequencer_if #(parameter int ADDR_W = 19);
    logic              job_valid;
    logic              job_ready;
    logic [15:0]       job_x;
    logic [15:0]       job_y;
    logic [7:0]        job_fx;
    logic [7:0]        job_fy;
    logic [ADDR_W-1:0] job_addr;
    modport master (output job_valid, job_x, job_y, job_fx, job_fy, job_addr, input job_ready);
    modport slave  (input job_valid, job_x, job_y, job_fx, job_fy, job_addr, output job_ready);
endinterface

// File: rtl/downscale_sequencer.sv
// downscale_sequencer: raster-order Q16.8 coordinate walker issuing one bilinear job per output pixel
module downscale_sequencer #(
    parameter int                ADDR_W   = 19,
    parameter logic [ADDR_W-1:0] OUT_BASE = 'h40000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_req,
    input  logic                   abort,
    input  logic [15:0]            cfg_width,
    input  logic [15:0]            cfg_height,
    input  logic [15:0]            cfg_scale,
    input  logic                   step_mode,
    input  logic                   step_pulse,
    input  logic                   dp_idle,
    downscale_sequencer_if.master  job,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [15:0]            out_w,
    output logic [15:0]            out_h
);
    typedef enum logic [2:0] {IDLE, ISSUE, STEP_WAIT, DRAIN, DONE} state_t;
    state_t            state_q, state_d;
    logic              start_q;
    logic [23:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d, nx, ny;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       col_q, col_d, row_q, row_d, row_w_q, row_w_d;
    logic [15:0]       out_w_q, out_w_d, out_h_q, out_h_d;
    logic              done_q, done_d, err_q, err_d;
    logic              start_ok, cfg_bad, accept;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            row_w_q <= '0;
            out_w_q <= '0;
            out_h_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_req;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            row_w_q <= row_w_d;
            out_w_q <= out_w_d;
            out_h_q <= out_h_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign start_ok = start_req && !start_q && (state_q == IDLE || state_q == DONE);
    assign cfg_bad  = cfg_width < 16'd2 || cfg_height < 16'd2 || cfg_scale < 16'h0100;
    assign accept   = state_q == ISSUE && job.job_ready;
    assign nx       = acc_x_q + {8'b0, cfg_scale};
    assign ny       = acc_y_q + {8'b0, cfg_scale};
    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        row_w_d = row_w_q;
        out_w_d = out_w_q;
        out_h_d = out_h_q;
        done_d  = done_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start_ok) begin
            done_d  = 1'b0;
            err_d   = cfg_bad;
            state_d = cfg_bad ? IDLE : ISSUE;
            acc_x_d = cfg_bad ? acc_x_q : '0;
            acc_y_d = cfg_bad ? acc_y_q : '0;
            addr_d  = cfg_bad ? addr_q : OUT_BASE;
            col_d   = cfg_bad ? col_q : '0;
            row_d   = cfg_bad ? row_q : '0;
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            if (nx[23:8] < cfg_width - 16'd1) begin
                acc_x_d = nx;
                col_d   = col_q + 16'd1;
                state_d = step_mode ? STEP_WAIT : ISSUE;
            end else begin
                acc_x_d = '0;
                col_d   = '0;
                row_w_d = col_q + 16'd1;
                if (ny[23:8] < cfg_height - 16'd1) begin
                    acc_y_d = ny;
                    row_d   = row_q + 16'd1;
                    state_d = step_mode ? STEP_WAIT : ISSUE;
                end else begin
                    state_d = DRAIN;
                end
            end
        end else if (state_q == STEP_WAIT) begin
            state_d = (step_pulse || !step_mode) ? ISSUE : STEP_WAIT;
        end else if (state_q == DRAIN && dp_idle) begin
            out_w_d = row_w_q;
            out_h_d = row_q + 16'd1;
            done_d  = 1'b1;
            state_d = DONE;
        end
    end
    always_comb begin
        job.job_valid = state_q == ISSUE;
        job.job_x     = acc_x_q[23:8];
        job.job_fx    = acc_x_q[7:0];
        job.job_y     = acc_y_q[23:8];
        job.job_fy    = acc_y_q[7:0];
        job.job_addr  = addr_q;
        busy          = state_q == ISSUE || state_q == STEP_WAIT || state_q == DRAIN;
        done          = done_q;
        cfg_err       = err_q;
        out_w         = out_w_q;
        out_h         = out_h_q;
    end
endmodule
